// File: rtl/line_render_ctrl.sv
// Per-scanline tile renderer: walks the 64 cells of one text row, fetching char code,
// 2bpp glyph row and palette colours, and streams 512 RGB332 pixels into a line RAM bank.
module line_render_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_start,
  input  logic [8:0]  line_y,
  input  logic        bank,
  output logic        char_en,
  output logic [11:0] char_addr,
  input  logic [7:0]  char_din,
  output logic        glyph_en,
  output logic [11:0] glyph_addr,
  input  logic [7:0]  glyph_din,
  output logic        pal_en,
  output logic [10:0] pal_addr,
  input  logic [7:0]  pal_din,
  output logic        line_we,
  output logic [9:0]  line_addr,
  output logic [7:0]  line_dout,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE,
    CHAR,
    GLO,
    GHI,
    PIX,
    FLUSH
  } state_t;

  state_t      state, state_nx;
  logic [8:0]  y_q;
  logic        bank_q;
  logic [5:0]  col, col_nx;
  logic [2:0]  px, px_nx;
  logic [7:0]  code, lo, hi;
  logic        wr_pend;
  logic [9:0]  wr_addr;
  logic [7:0]  pix_src;
  logic [1:0]  idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      y_q     <= '0;
      bank_q  <= 1'b0;
      col     <= '0;
      px      <= '0;
      code    <= '0;
      lo      <= '0;
      hi      <= '0;
      wr_pend <= 1'b0;
      wr_addr <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      col     <= col_nx;
      px      <= px_nx;
      if (line_start) begin
        y_q    <= line_y;
        bank_q <= bank;
        if (state != IDLE) overrun <= 1'b1;
      end
      if (state == GLO) code <= char_din;
      if (state == GHI) lo <= glyph_din;
      if (state == PIX && px == 3'd0) hi <= glyph_din;
      // Write address is captured with the lookup so an abort cannot retarget it.
      wr_pend <= (state == PIX);
      wr_addr <= {bank_q, col, px};
      done    <= (state == FLUSH);
    end
  end

  always_comb begin
    state_nx = state;
    col_nx   = col;
    px_nx    = px;
    if (line_start) begin
      state_nx = CHAR;
      col_nx   = '0;
      px_nx    = '0;
    end else begin
      case (state)
        CHAR:  state_nx = GLO;
        GLO:   state_nx = GHI;
        GHI: begin
          state_nx = PIX;
          px_nx    = '0;
        end
        PIX: begin
          if (px == 3'd7) begin
            px_nx = '0;
            if (col == 6'd63) begin
              state_nx = FLUSH;
            end else begin
              col_nx   = col + 6'd1;
              state_nx = CHAR;
            end
          end else begin
            px_nx = px + 3'd1;
          end
        end
        FLUSH: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // The code byte is consumed straight off the char RAM port in GLO to keep 11 cycles/cell.
  always_comb begin
    pix_src = px[2] ? hi : lo;
    case (px[1:0])
      2'd0:    idx = pix_src[7:6];
      2'd1:    idx = pix_src[5:4];
      2'd2:    idx = pix_src[3:2];
      default: idx = pix_src[1:0];
    endcase
    char_en    = (state == CHAR);
    char_addr  = {y_q[8:3], col};
    glyph_en   = (state == GLO) || (state == GHI);
    glyph_addr = {((state == GLO) ? char_din : code), y_q[2:0], (state == GHI)};
    pal_en     = (state == PIX);
    pal_addr   = {code, idx, 1'b0};
    line_we    = wr_pend;
    line_addr  = wr_addr;
    line_dout  = wr_pend ? pal_din : '0;
    busy       = (state != IDLE);
  end

endmodule
